// File: rtl/if_pkg.sv
// Shared constants and FSM state encoding for the instruction-fetch slice.
package if_pkg;

  localparam int unsigned     XLEN      = 32;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of PC, instruction-memory and IF/ID signals around the fetch unit.
interface if_fetch_unit_if;
  import if_pkg::*;

  logic [XLEN-1:0] pc;
  logic            pc_write;
  logic [XLEN-1:0] next_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            id_stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;

  modport master (
    input  pc, imem_ack, imem_rdata, id_stall, redirect, redirect_target,
    output pc_write, next_pc, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr
  );

  modport slave (
    output pc, imem_ack, imem_rdata, id_stall, redirect, redirect_target,
    input  pc_write, next_pc, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr
  );

endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register plus a one-entry skid buffer that catches a fetch
// response arriving while decode is stalled.
module if_id_skid
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_stall,
  input  logic            load_fetch,
  input  logic            push_skid,
  input  logic            pop_skid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  output logic            accept,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            skid_valid,
  output logic [XLEN-1:0] skid_pc
);

  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;

  assign accept     = !ifid_valid_q || !id_stall;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign skid_valid = skid_valid_q;
  assign skid_pc    = skid_pc_q;

  // Next IF/ID and skid contents; flush beats every load.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else if (load_fetch) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = fetch_pc;
      ifid_instr_d = fetch_instr;
    end else if (pop_skid) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = skid_pc_q;
      ifid_instr_d = skid_instr_q;
      skid_valid_d = 1'b0;
    end else if (push_skid) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = fetch_pc;
      skid_instr_d = fetch_instr;
    end else if (ifid_valid_q && !id_stall) begin
      ifid_valid_d = 1'b0;
    end else begin
      ifid_valid_d = ifid_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= {XLEN{1'b0}};
      ifid_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= {XLEN{1'b0}};
      skid_instr_q <= 32'd0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: single-outstanding imem handshake, PC update,
// decode back-pressure and redirect handling.
module if_fetch_unit
  import if_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  if_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] disc_addr_q, disc_addr_d;

  logic            pc_write_s;
  logic [XLEN-1:0] next_pc_s;
  logic            imem_req_s;
  logic [XLEN-1:0] imem_addr_s;
  logic            load_fetch_s, push_skid_s, pop_skid_s, flush_s;
  logic            accept_s, skid_valid_s;
  logic [XLEN-1:0] skid_pc_s;
  logic            ifid_valid_s;
  logic [XLEN-1:0] ifid_pc_s;
  logic [31:0]     ifid_instr_s;

  if_id_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_s),
    .id_stall    (bus.id_stall),
    .load_fetch  (load_fetch_s),
    .push_skid   (push_skid_s),
    .pop_skid    (pop_skid_s),
    .fetch_pc    (bus.pc),
    .fetch_instr (bus.imem_rdata),
    .accept      (accept_s),
    .ifid_valid  (ifid_valid_s),
    .ifid_pc     (ifid_pc_s),
    .ifid_instr  (ifid_instr_s),
    .skid_valid  (skid_valid_s),
    .skid_pc     (skid_pc_s)
  );

  // Request depends only on state and PC so a same-cycle ack cannot loop back into it.
  always_comb begin
    imem_req_s  = 1'b0;
    imem_addr_s = bus.pc;
    if (rst) begin
      imem_req_s = 1'b0;
    end else begin
      case (state_q)
        FETCH:   imem_req_s = 1'b1;
        DISCARD: begin
          imem_req_s  = 1'b1;
          imem_addr_s = disc_addr_q;
        end
        default: imem_req_s = 1'b0;
      endcase
    end
  end

  // Next state, PC update and IF/ID control.
  always_comb begin
    state_d      = state_q;
    disc_addr_d  = disc_addr_q;
    pc_write_s   = 1'b0;
    next_pc_s    = bus.pc + PC_INC;
    load_fetch_s = 1'b0;
    push_skid_s  = 1'b0;
    pop_skid_s   = 1'b0;
    flush_s      = 1'b0;
    if (rst) begin
      state_d = IDLE;
    end else if (bus.redirect) begin
      pc_write_s = 1'b1;
      next_pc_s  = bus.redirect_target;
      flush_s    = 1'b1;
      case (state_q)
        FETCH: begin
          if (!bus.imem_ack) begin
            disc_addr_d = bus.pc;
            state_d     = DISCARD;
          end else begin
            state_d = FETCH;
          end
        end
        // An ack landing here retires the abandoned request, so no further discard is needed.
        DISCARD: state_d = bus.imem_ack ? FETCH : DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (bus.imem_ack && accept_s) begin
            load_fetch_s = 1'b1;
            pc_write_s   = 1'b1;
            state_d      = FETCH;
          end else if (bus.imem_ack) begin
            push_skid_s = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (accept_s && skid_valid_s) begin
            pop_skid_s = 1'b1;
            pc_write_s = 1'b1;
            next_pc_s  = skid_pc_s + PC_INC;
            state_d    = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        DISCARD: state_d = bus.imem_ack ? FETCH : DISCARD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      disc_addr_q <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      disc_addr_q <= disc_addr_d;
    end
  end

  assign bus.pc_write   = pc_write_s;
  assign bus.next_pc    = next_pc_s;
  assign bus.imem_req   = imem_req_s;
  assign bus.imem_addr  = imem_addr_s;
  assign bus.ifid_valid = ifid_valid_s;
  assign bus.ifid_pc    = ifid_pc_s;
  assign bus.ifid_instr = ifid_instr_s;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scoreboard bench for if_fetch_unit with a PC register and a
// memory whose response word is 0xA0000000 | address.
module tb_if_fetch_unit;
  import if_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;
  logic zero_wait;
  logic ack_man;
  logic [31:0] pc_q;
  exp_t sb_q[$];
  int n_cmp;
  int n_err;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) pc_q <= 32'd0;
    else if (bus.pc_write) pc_q <= bus.next_pc;
  end

  assign bus.pc         = pc_q;
  assign bus.imem_ack   = zero_wait ? bus.imem_req : ack_man;
  assign bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = 32'hA000_0000 | a;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, {31'd0, bus.ifid_valid}, 32'd1);
      chk({tag, "_pc"}, bus.ifid_pc, e.pc);
      chk({tag, "_instr"}, bus.ifid_instr, e.instr);
    end
  endtask

  task automatic zero_wait_run(input int n, input logic [31:0] start);
    logic [31:0] a;
    zero_wait = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      #1;
      chk("zw_req", {31'd0, bus.imem_req}, 32'd1);
      chk("zw_addr", bus.imem_addr, a);
      chk("zw_pcw", {31'd0, bus.pc_write}, 32'd1);
      chk("zw_npc", bus.next_pc, a + 32'd4);
      push_exp(a);
      cyc();
      pop_check("zw_ifid");
    end
    zero_wait = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    zero_wait = 1'b0;
    ack_man = 1'b0;
    bus.id_stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'd0;
    repeat (2) cyc();

    // Reset state
    chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_pc", bus.ifid_pc, 32'd0);
    chk("rst_instr", bus.ifid_instr, 32'h0000_0013);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_pcw", {31'd0, bus.pc_write}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    chk("idle_pcw", {31'd0, bus.pc_write}, 32'd0);
    cyc();

    // Test 1: zero-wait streaming 0,4,8,C
    zero_wait_run(4, 32'h0000_0000);

    // Test 2: three wait cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t2_addr", bus.imem_addr, 32'h10);
      chk("t2_pcw", {31'd0, bus.pc_write}, 32'd0);
      if (i == 1) chk("t2_consumed", {31'd0, bus.ifid_valid}, 32'd0);
      cyc();
    end
    ack_man = 1'b1;
    #1;
    chk("t2_ack_pcw", {31'd0, bus.pc_write}, 32'd1);
    chk("t2_ack_npc", bus.next_pc, 32'h14);
    chk("t2_ack_addr", bus.imem_addr, 32'h10);
    push_exp(32'h10);
    cyc();
    ack_man = 1'b0;
    pop_check("t2_ifid");

    // Test 3: stall into HOLD at 0x20
    zero_wait_run(3, 32'h14);
    bus.id_stall = 1'b1;
    ack_man = 1'b1;
    #1;
    chk("t3_pcw", {31'd0, bus.pc_write}, 32'd0);
    chk("t3_addr", bus.imem_addr, 32'h20);
    push_exp(32'h20);
    cyc();
    ack_man = 1'b0;
    #1;
    chk("t3_hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t3_hold_pcw", {31'd0, bus.pc_write}, 32'd0);
    chk("t3_hold_pc", bus.ifid_pc, 32'h1C);
    chk("t3_hold_valid", {31'd0, bus.ifid_valid}, 32'd1);
    cyc();
    chk("t3_hold2_pc", bus.ifid_pc, 32'h1C);
    bus.id_stall = 1'b0;
    #1;
    chk("t3_rel_pcw", {31'd0, bus.pc_write}, 32'd1);
    chk("t3_rel_npc", bus.next_pc, 32'h24);
    chk("t3_rel_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    pop_check("t3_ifid");

    // Test 4: redirect to 0x100 while 0x30 is outstanding
    zero_wait_run(3, 32'h24);
    #1;
    chk("t4_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t4_addr", bus.imem_addr, 32'h30);
    cyc();
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h100;
    #1;
    chk("t4_pcw", {31'd0, bus.pc_write}, 32'd1);
    chk("t4_npc", bus.next_pc, 32'h100);
    chk("t4_addr_rd", bus.imem_addr, 32'h30);
    cyc();
    bus.redirect = 1'b0;
    #1;
    chk("t4_disc_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("t4_disc_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t4_disc_addr", bus.imem_addr, 32'h30);
    chk("t4_disc_pcw", {31'd0, bus.pc_write}, 32'd0);
    cyc();
    ack_man = 1'b1;
    #1;
    chk("t4_ack_addr", bus.imem_addr, 32'h30);
    chk("t4_ack_pcw", {31'd0, bus.pc_write}, 32'd0);
    cyc();
    ack_man = 1'b0;
    #1;
    chk("t4_new_addr", bus.imem_addr, 32'h100);
    chk("t4_new_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t4_new_valid", {31'd0, bus.ifid_valid}, 32'd0);
    ack_man = 1'b1;
    #1;
    chk("t4_new_pcw", {31'd0, bus.pc_write}, 32'd1);
    chk("t4_new_npc", bus.next_pc, 32'h104);
    push_exp(32'h100);
    cyc();
    ack_man = 1'b0;
    pop_check("t4_ifid");

    // Test 5: redirect coinciding with an ack (to 0x40, then to 0x200)
    ack_man = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h40;
    #1;
    chk("t5a_npc", bus.next_pc, 32'h40);
    cyc();
    bus.redirect = 1'b0;
    ack_man = 1'b0;
    #1;
    chk("t5a_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("t5a_instr", bus.ifid_instr, 32'h0000_0013);
    chk("t5a_addr", bus.imem_addr, 32'h40);
    ack_man = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h200;
    #1;
    chk("t5_pcw", {31'd0, bus.pc_write}, 32'd1);
    chk("t5_npc", bus.next_pc, 32'h200);
    cyc();
    ack_man = 1'b0;
    bus.redirect = 1'b0;
    #1;
    chk("t5_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("t5_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t5_addr", bus.imem_addr, 32'h200);
    ack_man = 1'b1;
    #1;
    chk("t5_npc2", bus.next_pc, 32'h204);
    push_exp(32'h200);
    cyc();
    ack_man = 1'b0;
    pop_check("t5_ifid");

    // Test 6: reset while in HOLD, with a redirect that reset must override
    bus.id_stall = 1'b1;
    ack_man = 1'b1;
    #1;
    chk("t6_pcw", {31'd0, bus.pc_write}, 32'd0);
    cyc();
    ack_man = 1'b0;
    #1;
    chk("t6_hold_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h300;
    #1;
    chk("t6_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t6_rst_pcw", {31'd0, bus.pc_write}, 32'd0);
    cyc();
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.id_stall = 1'b0;
    #1;
    chk("t6_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("t6_instr", bus.ifid_instr, 32'h0000_0013);
    chk("t6_pc", bus.ifid_pc, 32'd0);
    chk("t6_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t6_idle_pcw", {31'd0, bus.pc_write}, 32'd0);
    cyc();
    #1;
    chk("t6_fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t6_fetch_addr", bus.imem_addr, 32'd0);
    chk("t6_valid2", {31'd0, bus.ifid_valid}, 32'd0);

    // Wrap-around of the sequential increment
    ack_man = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    #1;
    chk("wrap_redir_npc", bus.next_pc, 32'hFFFF_FFFC);
    cyc();
    bus.redirect = 1'b0;
    #1;
    chk("wrap_pcw", {31'd0, bus.pc_write}, 32'd1);
    chk("wrap_npc", bus.next_pc, 32'd0);
    push_exp(32'hFFFF_FFFC);
    cyc();
    ack_man = 1'b0;
    pop_check("wrap_ifid");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
